// File: rtl/layer_sequencer_if.sv
// Memory and neuron_processor side of layer_sequencer: weight/threshold read
// ports plus the beat stream towards the neuron_processor and its result.
interface layer_sequencer_if #(
    parameter int NUM_INPUTS      = 784,
    parameter int NUM_NEURONS     = 256,
    parameter int PARALLEL_INPUTS = 8,
    parameter int THRESH_WIDTH    = 32
);
    localparam int BEATS = (NUM_INPUTS + PARALLEL_INPUTS - 1) / PARALLEL_INPUTS;
    localparam int WA_W  = (NUM_NEURONS * BEATS > 1) ? $clog2(NUM_NEURONS * BEATS) : 1;
    localparam int TA_W  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    logic                       wt_rd_en;
    logic [WA_W-1:0]            wt_rd_addr;
    logic [PARALLEL_INPUTS-1:0] wt_rd_data;
    logic                       thr_rd_en;
    logic [TA_W-1:0]            thr_rd_addr;
    logic [THRESH_WIDTH-1:0]    thr_rd_data;
    logic [PARALLEL_INPUTS-1:0] np_inputs;
    logic [PARALLEL_INPUTS-1:0] np_weights;
    logic [THRESH_WIDTH-1:0]    np_threshold;
    logic                       np_inputs_valid;
    logic                       np_weights_valid;
    logic                       np_out_valid;
    logic                       np_out;

    modport master (
        output wt_rd_en, wt_rd_addr, thr_rd_en, thr_rd_addr,
               np_inputs, np_weights, np_threshold, np_inputs_valid, np_weights_valid,
        input  wt_rd_data, thr_rd_data, np_out_valid, np_out
    );

    modport slave (
        input  wt_rd_en, wt_rd_addr, thr_rd_en, thr_rd_addr,
               np_inputs, np_weights, np_threshold, np_inputs_valid, np_weights_valid,
        output wt_rd_data, thr_rd_data, np_out_valid, np_out
    );
endinterface

// File: rtl/layer_sequencer.sv
// Walks every neuron of a binary FC layer: fetch threshold, stream weight/activation
// beats to one neuron_processor, collect its result bit into out_vec.
module layer_sequencer #(
    parameter int NUM_INPUTS      = 784,
    parameter int NUM_NEURONS     = 256,
    parameter int PARALLEL_INPUTS = 8,
    parameter int THRESH_WIDTH    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NUM_INPUTS-1:0]  in_bits,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_NEURONS-1:0] out_vec,
    output logic                   err,
    layer_sequencer_if.master      bus
);
    localparam int PI    = PARALLEL_INPUTS;
    localparam int BEATS = (NUM_INPUTS + PI - 1) / PI;
    localparam int PW    = BEATS * PI;
    localparam int WA_W  = (NUM_NEURONS * BEATS > 1) ? $clog2(NUM_NEURONS * BEATS) : 1;
    localparam int TA_W  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int BT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {IDLE, THR, STREAM, WAIT_OUT, DONE} state_t;

    state_t                  state, nxt;
    logic [NUM_INPUTS-1:0]   in_q;
    logic [TA_W-1:0]         neuron;
    logic [BT_W-1:0]         beat;
    logic                    thr_pend;
    logic [THRESH_WIDTH-1:0] thr_q;
    logic                    np_vld;
    logic [PI-1:0]           in_slice_q;
    logic [PI-1:0]           keep_q;
    logic [PW-1:0]           in_pad;
    logic [PW-1:0]           wt_keep;

    wire last_beat   = (beat == BT_W'(BEATS - 1));
    wire last_neuron = (neuron == TA_W'(NUM_NEURONS - 1));

    // Pad positions past NUM_INPUTS: activation 1, weight forced 0 -> XNOR is 0.
    for (genvar i = 0; i < PW; i++) begin : g_pad
        if (i < NUM_INPUTS) begin : g_act
            assign in_pad[i]  = in_q[i];
            assign wt_keep[i] = 1'b1;
        end else begin : g_fill
            assign in_pad[i]  = 1'b1;
            assign wt_keep[i] = 1'b0;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:     if (start) nxt = THR;
            THR:      nxt = STREAM;
            STREAM:   if (last_beat) nxt = WAIT_OUT;
            WAIT_OUT: if (bus.np_out_valid) nxt = last_neuron ? DONE : THR;
            DONE:     nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    assign done                 = (state == DONE);
    assign bus.thr_rd_en        = (state == THR);
    assign bus.thr_rd_addr      = bus.thr_rd_en ? neuron : '0;
    assign bus.wt_rd_en         = (state == STREAM);
    assign bus.wt_rd_addr       = bus.wt_rd_en ?
                                  (WA_W'(neuron) * WA_W'(BEATS) + WA_W'(beat)) : '0;
    assign bus.np_inputs        = in_slice_q;
    assign bus.np_weights       = np_vld ? (bus.wt_rd_data & keep_q) : '0;
    assign bus.np_threshold     = thr_q;
    assign bus.np_inputs_valid  = np_vld;
    assign bus.np_weights_valid = np_vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            err        <= 1'b0;
            out_vec    <= '0;
            in_q       <= '0;
            neuron     <= '0;
            beat       <= '0;
            thr_pend   <= 1'b0;
            thr_q      <= '0;
            np_vld     <= 1'b0;
            in_slice_q <= '0;
            keep_q     <= '0;
        end else begin
            state    <= nxt;
            thr_pend <= (state == THR);
            if (thr_pend) thr_q <= bus.thr_rd_data;
            // Activation slice and pad mask lag one cycle to line up with read data.
            np_vld <= (state == STREAM);
            if (state == STREAM) begin
                in_slice_q <= in_pad[beat*PI +: PI];
                keep_q     <= wt_keep[beat*PI +: PI];
                beat       <= last_beat ? '0 : beat + 1'b1;
            end
            if (bus.np_out_valid && state != WAIT_OUT) err <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    in_q    <= in_bits;
                    out_vec <= '0;
                    err     <= 1'b0;
                    busy    <= 1'b1;
                    neuron  <= '0;
                end
                THR: beat <= '0;
                WAIT_OUT: if (bus.np_out_valid) begin
                    out_vec[neuron] <= bus.np_out;
                    if (!last_neuron) neuron <= neuron + 1'b1;
                end
                DONE: busy <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer with 10 inputs, 4-bit beats, 3 neurons.
module tb_layer_sequencer;
    localparam int NI = 10, NN = 3, PI = 4, TW = 32;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [NI-1:0] in_bits = '0;
    logic busy, done, err;
    logic [NN-1:0] out_vec;
    int total = 0, bad = 0;

    layer_sequencer_if #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .PARALLEL_INPUTS(PI),
                         .THRESH_WIDTH(TW)) bus ();

    layer_sequencer #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .PARALLEL_INPUTS(PI),
                      .THRESH_WIDTH(TW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_bits(in_bits), .busy(busy),
        .done(done), .out_vec(out_vec), .err(err), .bus(bus));

    always #5 clk = ~clk;

    logic [3:0]    wt_mem [9];
    logic [TW-1:0] thr_mem [3];
    logic [NI-1:0] wts [3] = '{10'b1011001110, 10'b0100110001, 10'b1011000001};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.wt_rd_data  <= '0;
            bus.thr_rd_data <= '0;
        end else begin
            if (bus.wt_rd_en)  bus.wt_rd_data  <= wt_mem[bus.wt_rd_addr];
            if (bus.thr_rd_en) bus.thr_rd_data <= thr_mem[bus.thr_rd_addr];
        end
    end

    // Behavioural neuron_processor: XNOR-popcount >= threshold, 2 cycles after last beat.
    logic [31:0] acc;
    logic prev, res, mv, mo, inj = 1'b0;
    logic [1:0] dly;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0; prev <= 1'b0; res <= 1'b0; mv <= 1'b0; mo <= 1'b0; dly <= '0;
        end else begin
            mv   <= 1'b0;
            prev <= bus.np_inputs_valid;
            if (bus.np_inputs_valid)
                acc <= acc + 32'($countones(~(bus.np_inputs ^ bus.np_weights)));
            if (prev && !bus.np_inputs_valid) begin
                res <= (acc >= bus.np_threshold);
                acc <= '0;
                dly <= 2'd2;
            end else if (dly != 2'd0) begin
                dly <= dly - 2'd1;
                if (dly == 2'd1) begin mv <= 1'b1; mo <= res; end
            end
        end
    end
    assign bus.np_out_valid = mv | inj;
    assign bus.np_out       = inj ? 1'b1 : mo;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic [3:0] wt_q [$];
    logic [1:0] thr_q [$];
    logic [7:0] beat_q [$];
    logic [3:0] done_q [$];

    task automatic push_run(input logic [NI-1:0] x, input logic [NN-1:0] ov, input logic e);
        logic [11:0] ipad, w12;
        ipad = {2'b11, x};
        for (int n = 0; n < NN; n++) begin
            thr_q.push_back(2'(n));
            w12 = {2'b11, wts[n]};
            for (int b = 0; b < 3; b++) begin
                wt_q.push_back(4'(n * 3 + b));
                beat_q.push_back({ipad[b*4 +: 4], w12[b*4 +: 4] & ((b == 2) ? 4'b0011 : 4'b1111)});
            end
        end
        done_q.push_back({e, ov});
    endtask

    // Monitor: every DUT-presented read, beat and done is matched against the queues.
    int run = 0;
    always @(negedge clk) begin
        if (!rst) run = 0;
        else begin
            if (bus.thr_rd_en) begin
                if (thr_q.size() == 0) chk("thr_unexpected", 1, 0);
                else chk("thr_addr", 64'(bus.thr_rd_addr), 64'(thr_q.pop_front()));
            end
            if (bus.wt_rd_en) begin
                if (wt_q.size() == 0) chk("wt_unexpected", 1, 0);
                else chk("wt_addr", 64'(bus.wt_rd_addr), 64'(wt_q.pop_front()));
            end
            if (bus.np_inputs_valid != bus.np_weights_valid)
                chk("valid_pair", 64'(bus.np_weights_valid), 64'(bus.np_inputs_valid));
            if (bus.np_inputs_valid) begin
                run++;
                chk("np_threshold", 64'(bus.np_threshold), 64'd5);
                if (beat_q.size() == 0) chk("beat_unexpected", 1, 0);
                else chk("np_beat", 64'({bus.np_inputs, bus.np_weights}), 64'(beat_q.pop_front()));
            end else if (run != 0) begin
                chk("beat_run", 64'(run), 64'd3);
                run = 0;
            end
            if (done) begin
                if (done_q.size() == 0) chk("done_unexpected", 1, 0);
                else chk("done_result", 64'({err, out_vec}), 64'(done_q.pop_front()));
            end
        end
    end

    task automatic do_start(input logic [NI-1:0] x);
        @(negedge clk); start = 1'b1; in_bits = x;
        @(negedge clk); start = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_clear", 64'({err, out_vec}), 64'd0);
    endtask

    task automatic wait_stream();
        int n = 0;
        do begin @(negedge clk); n++; end while (!bus.wt_rd_en && n < 50);
        if (!bus.wt_rd_en) chk("stream_timeout", 0, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin @(negedge clk); n++; end
        if (!done) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("busy_after_done", 64'({busy, done}), 64'd0);
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, 64'({busy, done, err, out_vec, bus.wt_rd_en, bus.thr_rd_en,
                     bus.np_inputs_valid, bus.np_weights_valid}), 64'd0);
        chk({nm, "_data"}, 64'({bus.np_inputs, bus.np_weights, bus.wt_rd_addr, bus.thr_rd_addr}), 64'd0);
        chk({nm, "_thr"}, 64'(bus.np_threshold), 64'd0);
    endtask

    localparam logic [NI-1:0] X1 = 10'b1011001110;

    initial begin
        for (int n = 0; n < NN; n++) begin
            logic [11:0] w12;
            w12 = {2'b11, wts[n]};
            thr_mem[n] = 32'd5;
            for (int b = 0; b < 3; b++) wt_mem[n*3 + b] = w12[b*4 +: 4];
        end
        repeat (5) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle", 64'({busy, bus.wt_rd_en, bus.thr_rd_en}), 64'd0);
        end

        // Main run with an ignored start mid-STREAM.
        push_run(X1, 3'b101, 1'b0);
        do_start(X1);
        wait_stream();
        start = 1'b1; in_bits = 10'h155;
        @(negedge clk); start = 1'b0;
        chk("busy_ignored_start", 64'(busy), 64'd1);
        wait_done();
        chk("out_hold", 64'(out_vec), 64'b101);

        // Spurious result during STREAM raises sticky err.
        push_run(X1, 3'b101, 1'b1);
        do_start(X1);
        wait_stream();
        inj = 1'b1;
        @(negedge clk); inj = 1'b0;
        chk("err_set", 64'({err, out_vec}), 64'b1000);
        wait_done();

        push_run(X1, 3'b101, 1'b0);
        do_start(X1);
        wait_done();

        // Reset mid-STREAM, then a fresh run with different activations.
        push_run(X1, 3'b101, 1'b0);
        do_start(X1);
        wait_stream();
        rst = 1'b0;
        #1;
        chk_zero("mid_reset");
        wt_q.delete(); thr_q.delete(); beat_q.delete(); done_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        push_run(10'h3FF, 3'b001, 1'b0);
        do_start(10'h3FF);
        wait_done();

        repeat (3) @(negedge clk);
        chk("queues_drained", 64'(wt_q.size() + thr_q.size() + beat_q.size() + done_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
